// File: rtl/spi_master_ram_driver.sv
// SPI master for the RAM slave: serialises {cmd_type, cmd_data} MSB first, captures the 8-bit read reply.
// One bit per clk; SS_n and MOSI are registered so the slave sees glitch-free lines.
module spi_master_ram_driver #(
  parameter int unsigned RD_GAP   = 2,
  parameter int unsigned IDLE_MIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_GAP,
    S_CAPTURE,
    S_END
  } state_e;

  localparam logic [3:0] SHIFT_LAST   = 4'd9;
  localparam logic [3:0] CAPTURE_LAST = 4'd7;
  localparam logic [3:0] GAP_LAST     = 4'(RD_GAP - 1);
  localparam logic [3:0] END_LAST     = 4'(IDLE_MIN - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  frame_q, frame_d;
  logic        is_rd_q, is_rd_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        accept;

  // Ready is held low while reset is asserted, even though the state is already IDLE.
  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    is_rd_d    = is_rd_q;
    shreg_d    = shreg_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          frame_d = {cmd_type, cmd_data};
          is_rd_d = (cmd_type == 2'b11);
          cnt_d   = 4'd0;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        cnt_d   = 4'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // MOSI always shows frame_q[9]; shifting left presents the next bit.
        frame_d = {frame_q[8:0], 1'b0};
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = 4'd0;
          state_d = is_rd_q ? S_GAP : S_END;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        shreg_d = {shreg_q[6:0], MISO};
        if (cnt_q == CAPTURE_LAST) begin
          cnt_d      = 4'd0;
          rd_data_d  = {shreg_q[6:0], MISO};
          rd_valid_d = 1'b1;
          state_d    = S_END;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_END: begin
        if (cnt_q == END_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Line levels are derived from the next state so they change on the same edge as the state.
  always_comb begin
    ss_n_d = !((state_d == S_LEAD) || (state_d == S_SHIFT) ||
               (state_d == S_GAP)  || (state_d == S_CAPTURE));
    mosi_d = 1'b0;
    if ((state_d == S_LEAD) || (state_d == S_SHIFT)) begin
      mosi_d = frame_d[9];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      frame_q    <= 10'd0;
      is_rd_q    <= 1'b0;
      shreg_q    <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      is_rd_q    <= is_rd_d;
      shreg_q    <= shreg_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q != S_IDLE);
  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_ram_driver.sv
// Bench for spi_master_ram_driver: two instances (RD_GAP=2/IDLE_MIN=1 and RD_GAP=4/IDLE_MIN=3)
// checked cycle by cycle against a frame-timing and RAM-slave reference model.
module tb_spi_master_ram_driver;

  localparam int G_A  = 2;
  localparam int IM_A = 1;
  localparam int G_B  = 4;
  localparam int IM_B = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic       MISO;
  logic       sel;

  logic       cmd_valid_a, rdy_a, rd_valid_a, busy_a, ss_n_a, mosi_a;
  logic [7:0] rd_data_a;
  logic       cmd_valid_b, rdy_b, rd_valid_b, busy_b, ss_n_b, mosi_b;
  logic [7:0] rd_data_b;

  logic       rdy_s, rd_valid_s, busy_s, ss_n_s, mosi_s;
  logic [7:0] rd_data_s;

  always #5 clk = ~clk;

  assign cmd_valid_a = cmd_valid & ~sel;
  assign cmd_valid_b = cmd_valid & sel;
  assign rdy_s       = sel ? rdy_b      : rdy_a;
  assign rd_valid_s  = sel ? rd_valid_b : rd_valid_a;
  assign busy_s      = sel ? busy_b     : busy_a;
  assign ss_n_s      = sel ? ss_n_b     : ss_n_a;
  assign mosi_s      = sel ? mosi_b     : mosi_a;
  assign rd_data_s   = sel ? rd_data_b  : rd_data_a;

  spi_master_ram_driver #(.RD_GAP(G_A), .IDLE_MIN(IM_A)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(rdy_a),
    .cmd_type(cmd_type), .cmd_data(cmd_data), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .busy(busy_a), .SS_n(ss_n_a), .MOSI(mosi_a), .MISO(MISO)
  );

  spi_master_ram_driver #(.RD_GAP(G_B), .IDLE_MIN(IM_B)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(rdy_b),
    .cmd_type(cmd_type), .cmd_data(cmd_data), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .busy(busy_b), .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(MISO)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int g_cur, im_cur;
  int last_t;
  logic [7:0] rd_exp;
  logic [7:0] ram [256];
  logic [7:0] wr_addr, rd_addr;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Drives one command, then checks every line against the frame timing rules until
  // cmd_ready is due again. hold keeps cmd_valid high with junk payload during the frame;
  // abort_k > 0 asserts rst in that cycle of the frame and returns.
  task automatic run_frame(input logic [1:0] ty, input logic [7:0] d, input bit hold,
                           input int abort_k);
    logic [9:0] f;
    logic [7:0] reply;
    bit         rd;
    int         w, last;
    logic       ss_e, mosi_e, rdy_e, busy_e, rv_e;
    cmd_type  = ty;
    cmd_data  = d;
    cmd_valid = 1'b1;
    w = 0;
    while (rdy_s !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (rdy_s !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%b, required 1 within 100 cycles", rdy_s);
      cmd_valid = 1'b0;
      return;
    end
    last_t = cyc;
    f      = {ty, d};
    rd     = (ty == 2'b11);
    reply  = 8'h00;
    case (ty)
      2'b00: wr_addr = d;
      2'b01: ram[wr_addr] = d;
      2'b10: rd_addr = d;
      default: reply = ram[rd_addr];
    endcase
    last = rd ? (20 + g_cur + im_cur) : (12 + im_cur);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      if (rd && k >= 12 + g_cur && k <= 19 + g_cur) MISO = reply[7 - (k - 12 - g_cur)];
      else MISO = 1'($urandom);
      if (hold) begin
        cmd_type = 2'($urandom);
        cmd_data = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      ss_e   = !(k <= 11 || (rd && k <= 19 + g_cur));
      mosi_e = (k == 1) ? f[9] : ((k <= 11) ? f[11 - k] : 1'b0);
      rdy_e  = (k == last);
      busy_e = (k != last);
      rv_e   = rd && (k == 20 + g_cur);
      if (rv_e) rd_exp = reply;
      checks++;
      if (ss_n_s !== ss_e) begin
        errors++;
        $display("FAIL ss_n t+%0d: got %b want %b", k, ss_n_s, ss_e);
      end
      checks++;
      if (mosi_s !== mosi_e) begin
        errors++;
        $display("FAIL mosi t+%0d: got %b want %b (frame %h)", k, mosi_s, mosi_e, f);
      end
      checks++;
      if (rdy_s !== rdy_e) begin
        errors++;
        $display("FAIL cmd_ready t+%0d: got %b want %b", k, rdy_s, rdy_e);
      end
      checks++;
      if (busy_s !== busy_e) begin
        errors++;
        $display("FAIL busy t+%0d: got %b want %b", k, busy_s, busy_e);
      end
      checks++;
      if (rd_valid_s !== rv_e) begin
        errors++;
        $display("FAIL rd_valid t+%0d: got %b want %b", k, rd_valid_s, rv_e);
      end
      checks++;
      if (rd_data_s !== rd_exp) begin
        errors++;
        $display("FAIL rd_data t+%0d: got %h want %h", k, rd_data_s, rd_exp);
      end
      if (k == abort_k) begin
        rst = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rdy_a !== 1'b0 || busy_a !== 1'b0 || rd_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready/busy/rd_valid=%b%b%b want 000", rdy_a, busy_a, rd_valid_a);
    end
    checks++;
    if (ss_n_a !== 1'b1 || mosi_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_lines: SS_n/MOSI=%b%b want 10", ss_n_a, mosi_a);
    end
    checks++;
    if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_rd_data: got %h/%h want 00/00", rd_data_a, rd_data_b);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b/%b want 1/1", rdy_a, rdy_b);
    end
    rd_exp = 8'h00;
  endtask

  task automatic test_write_addr();
    run_frame(2'b00, 8'hA5, 1'b0, 0);
  endtask

  task automatic test_write_read();
    run_frame(2'b00, 8'h10, 1'b0, 0);
    run_frame(2'b01, 8'h3C, 1'b0, 0);
    run_frame(2'b10, 8'h10, 1'b0, 0);
    run_frame(2'b11, 8'($urandom), 1'b0, 0);
    checks++;
    if (rd_data_s !== 8'h3C) begin
      errors++;
      $display("FAIL write_read_data: got %h want 3c", rd_data_s);
    end
  endtask

  task automatic test_ready_handshake();
    int t1;
    logic [7:0] d2;
    run_frame(2'b10, 8'h5A, 1'b1, 0);
    t1 = last_t;
    d2 = 8'($urandom);
    run_frame(2'b00, d2, 1'b0, 0);
    checks++;
    if (last_t - t1 !== 12 + IM_A) begin
      errors++;
      $display("FAIL handshake_spacing: got %0d want %0d", last_t - t1, 12 + IM_A);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      run_frame(2'b01, 8'($urandom), (i < 2), 0);
      if (i > 0) begin
        checks++;
        if (last_t - t0 !== 12 + IM_A) begin
          errors++;
          $display("FAIL b2b_spacing %0d: got %0d want %0d", i, last_t - t0, 12 + IM_A);
        end
      end
      t0 = last_t;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_frame(2'($urandom), 8'($urandom), 1'($urandom), 0);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    run_frame(2'b11, 8'h00, 1'b0, 12 + G_A + 4);
    @(posedge clk); #1;
    rd_exp = 8'h00;
    checks++;
    if (ss_n_a !== 1'b1 || rd_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_lines: SS_n/rd_valid/busy=%b%b%b want 100", ss_n_a, rd_valid_a, busy_a);
    end
    checks++;
    if (rd_data_a !== 8'h00) begin
      errors++;
      $display("FAIL abort_rd_data: got %h want 00", rd_data_a);
    end
    checks++;
    if (rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready_in_reset: got %b want 0", rdy_a);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready_after: got %b want 1", rdy_a);
    end
  endtask

  task automatic test_param_sweep();
    sel    = 1'b1;
    g_cur  = G_B;
    im_cur = IM_B;
    rd_exp = 8'h00;
    @(posedge clk); #1;
    run_frame(2'b00, 8'h77, 1'b0, 0);
    run_frame(2'b01, 8'hC3, 1'b1, 0);
    run_frame(2'b10, 8'h77, 1'b0, 0);
    run_frame(2'b11, 8'h00, 1'b0, 0);
    checks++;
    if (rd_data_s !== 8'hC3) begin
      errors++;
      $display("FAIL sweep_rd_data: got %h want c3", rd_data_s);
    end
    for (int i = 0; i < 6; i++) begin
      run_frame(2'($urandom), 8'($urandom), 1'($urandom), 0);
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_type  = 2'b00;
    cmd_data  = 8'h00;
    MISO      = 1'b0;
    sel       = 1'b0;
    g_cur     = G_A;
    im_cur    = IM_A;
    rd_exp    = 8'h00;
    wr_addr   = 8'h00;
    rd_addr   = 8'h00;
    last_t    = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    test_reset();
    test_write_addr();
    test_write_read();
    test_ready_handshake();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
